branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- MEM-stage consumer of the branch-prediction metadata carried down the EX/MEM pipeline register.
- Resolves each branch and compares the actual outcome with the speculative fetch decision.
- On a misprediction, issues a one-cycle flush and a redirect PC.
- Queues 2-bit PHT counter write-backs in a small FIFO that drains into the PHT write port, and maintains global history and performance counters.

Parameters:
PHT_IDX_W, 10, PHT index width (1024 entries)
FIFO_DEPTH, 4, PHT update queue depth (power of 2, >=2)
GHR_W, 8, global history register width
CNT_W, 16, performance counter width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
res_valid  input  1  MEM stage holds a resolved conditional branch this cycle
res_taken  input  1  actual branch outcome
res_spec_taken  input  1  btb_speculatively_taken carried from fetch
res_pht_index  input  PHT_IDX_W  PHT index used at fetch
res_pht_pred  input  2  PHT counter value read at fetch
res_pc  input  16  address of the branch instruction
res_target  input  16  computed branch target
stall_req  output  1  MEM must hold; resolve not accepted this cycle
flush  output  1  one-cycle pulse: squash IF/ID/EX
redirect_pc  output  16  fetch PC, valid when flush=1
pht_we  output  1  PHT write strobe
pht_wr_index  output  PHT_IDX_W  PHT write index
pht_wr_data  output  2  new counter value
pht_wr_ready  input  1  PHT accepts write this cycle
ghr  output  GHR_W  global history, newest outcome in bit 0
branch_count  output  CNT_W  resolved branches
mispredict_count  output  CNT_W  mispredicted branches

Behaviour:
- Accept: accept = res_valid && !(fifo_full && !(pht_we && pht_wr_ready)). stall_req = res_valid && !accept (combinational). A full FIFO accepts only if it dequeues in the same cycle.
- All side effects occur only on accept, so a stalled resolve that repeats is counted once. Side effects are: flush, GHR, counters, enqueue.
- Mispredict: mispredict = res_spec_taken != res_taken.
- flush is registered and asserts the cycle after accept && mispredict, for exactly one cycle.
- redirect_pc is registered alongside flush: res_taken ? res_target : res_pc + 16'd2 (16-bit wrap, 0xFFFE+2 = 0x0000).
- Counter update: new = res_taken ? sat_inc(res_pht_pred) : sat_dec(res_pht_pred). The counter saturates at 2'b11 and 2'b00.
- Enqueue {res_pht_index, new} only when new != res_pht_pred; saturated no-change updates are dropped, but GHR and stats still update.
- FIFO drain: pht_we = !fifo_empty. pht_wr_index and pht_wr_data show the head entry. Dequeue on pht_we && pht_wr_ready. Head values stay stable while pht_we && !pht_wr_ready.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits with wrap-bit full/empty detection. Simultaneous enqueue and dequeue leaves occupancy unchanged.
- FIFO entries are strictly in order; there is no coalescing of same-index entries.
- GHR: on accept, ghr <= {ghr[GHR_W-2:0], res_taken}.
- branch_count increments on every accept. mispredict_count increments on accept && mispredict. Both saturate at all-ones.
- Reset (synchronous, dominates everything, including mid-drain): FIFO emptied, pht_we=0, flush=0, redirect_pc=0, ghr=0, both counters=0. Queued updates are discarded.
- res_valid asserted during reset is ignored.
- Latency: flush/redirect 1 cycle after accept. The earliest PHT write is 1 cycle after accept (entry visible at head next cycle).

Decomposition:
- lc3b_types additions: typedef lc3b_pht_ctr (logic [1:0]); typedef lc3b_pht_update (struct: index, ctr); constants PHT_STRONG_NT=2'b00, PHT_STRONG_T=2'b11.
- Functions sat_inc/sat_dec go in the package.
- One sub-module: pht_update_fifo. It is a generic synchronous FIFO of lc3b_pht_update with enq/deq/full/empty.

Test Plan:
- Predicted-taken branch, taken, pred=2'b10 -> no flush; PHT write idx, data 2'b11 next cycle; ghr bit0=1; branch_count=1, mispredict_count=0.
- spec_taken=1, actual not taken, pc=0x3000, pred=2'b10 -> flush one cycle with redirect_pc=0x3002; PHT write data 2'b01; mispredict_count=1.
- spec_taken=0, actual taken, target=0x4010 -> flush, redirect_pc=0x4010. pc=0xFFFE with not-taken mispredict -> redirect_pc=0x0000.
- Taken with pred=2'b11 -> no PHT write, ghr shifts, branch_count increments.
- pht_wr_ready=0 with 5 consecutive updating resolves -> first 4 enqueued; 5th stalls (stall_req=1, counted once). Raise ready -> 5th accepted in the same cycle as the first dequeue, and writes drain in order.
- Assert reset with 3 queued entries -> next cycle pht_we=0, ghr=0, counters=0, flush=0; no stale writes after release.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: PHT counter/update types, saturation helpers, shared widths
package branch_resolve_unit_pkg;
  localparam int PHT_IDX_W = 10;
  typedef logic [1:0] lc3b_pht_ctr;
  localparam lc3b_pht_ctr PHT_STRONG_NT = 2'b00;
  localparam lc3b_pht_ctr PHT_STRONG_T = 2'b11;
  typedef struct packed {
    logic [PHT_IDX_W-1:0] index;
    lc3b_pht_ctr ctr;
  } lc3b_pht_update;
  function automatic lc3b_pht_ctr sat_inc(lc3b_pht_ctr c);
    return (c == PHT_STRONG_T) ? c : c + 2'b01;
  endfunction
  function automatic lc3b_pht_ctr sat_dec(lc3b_pht_ctr c);
    return (c == PHT_STRONG_NT) ? c : c - 2'b01;
  endfunction
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: MEM resolve bus (res_*, stall_req) and PHT write port (pht_*)
// master = pipeline/PHT side, slave = branch_resolve_unit
interface branch_resolve_unit_if;
  import branch_resolve_unit_pkg::*;
  logic res_valid, res_taken, res_spec_taken;
  logic [PHT_IDX_W-1:0] res_pht_index;
  lc3b_pht_ctr res_pht_pred;
  logic [15:0] res_pc, res_target;
  logic stall_req;
  logic pht_we, pht_wr_ready;
  logic [PHT_IDX_W-1:0] pht_wr_index;
  lc3b_pht_ctr pht_wr_data;
  modport master (
    output res_valid, res_taken, res_spec_taken, res_pht_index, res_pht_pred, res_pc, res_target, pht_wr_ready,
    input stall_req, pht_we, pht_wr_index, pht_wr_data
  );
  modport slave (
    input res_valid, res_taken, res_spec_taken, res_pht_index, res_pht_pred, res_pc, res_target, pht_wr_ready,
    output stall_req, pht_we, pht_wr_index, pht_wr_data
  );
endinterface

// File: rtl/branch_resolve_unit_pht_update_fifo.sv
// pht_update_fifo: synchronous in-order FIFO of PHT updates
// ports: clk, reset, enq/din (push), deq (pop), dout (head), full, empty
module pht_update_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enq,
  input  lc3b_pht_update din,
  input  logic deq,
  output lc3b_pht_update dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  lc3b_pht_update mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  // extra wrap bit distinguishes full from empty when the index bits match
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (enq) begin
        mem_q[wr_q[AW-1:0]] <= din;
        wr_q <= wr_q + 1'b1;
      end
      if (deq) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: MEM-stage branch resolution, flush/redirect, PHT write-back queue, GHR and stats
// ports: clk, reset, bus (resolve + PHT write, slave), flush/redirect_pc, ghr, branch_count, mispredict_count
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GHR_W = 8,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  branch_resolve_unit_if.slave bus,
  output logic flush,
  output logic [15:0] redirect_pc,
  output logic [GHR_W-1:0] ghr,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  logic fifo_full, fifo_empty, deq, accept, mispredict, enq;
  lc3b_pht_ctr new_ctr;
  lc3b_pht_update head;
  logic flush_q, flush_d;
  logic [15:0] redirect_q, redirect_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [CNT_W-1:0] bc_q, bc_d, mc_q, mc_d;
  assign deq = !fifo_empty && bus.pht_wr_ready;
  // a full queue still accepts when its head leaves this same cycle
  assign accept = bus.res_valid && !(fifo_full && !deq);
  assign mispredict = bus.res_spec_taken != bus.res_taken;
  assign new_ctr = bus.res_taken ? sat_inc(bus.res_pht_pred) : sat_dec(bus.res_pht_pred);
  assign enq = accept && (new_ctr != bus.res_pht_pred);
  assign bus.stall_req = bus.res_valid && !accept;
  assign bus.pht_we = !fifo_empty;
  assign bus.pht_wr_index = head.index;
  assign bus.pht_wr_data = head.ctr;
  pht_update_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .enq(enq),
    .din('{index: bus.res_pht_index, ctr: new_ctr}),
    .deq(deq),
    .dout(head),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  always_comb begin
    flush_d = accept && mispredict;
    redirect_d = flush_d ? (bus.res_taken ? bus.res_target : bus.res_pc + 16'd2) : redirect_q;
    ghr_d = accept ? {ghr_q[GHR_W-2:0], bus.res_taken} : ghr_q;
    bc_d = (accept && !(&bc_q)) ? bc_q + 1'b1 : bc_q;
    mc_d = (flush_d && !(&mc_q)) ? mc_q + 1'b1 : mc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_q <= 1'b0;
      redirect_q <= '0;
      ghr_q <= '0;
      bc_q <= '0;
      mc_q <= '0;
    end else begin
      flush_q <= flush_d;
      redirect_q <= redirect_d;
      ghr_q <= ghr_d;
      bc_q <= bc_d;
      mc_q <= mc_d;
    end
  end
  assign flush = flush_q;
  assign redirect_pc = redirect_q;
  assign ghr = ghr_q;
  assign branch_count = bc_q;
  assign mispredict_count = mc_q;
endmodule
